// File: rtl/memory_bus.sv
// memory_bus: word-addressed RAM plus an MMIO window (UART TX with FIFO, cycle counter)
// serving the multicycle core. Reads are combinational so the core can capture them
// on the edge after it drives the address.
module memory_bus #(
  parameter int RAM_WORDS    = 1024,
  parameter     INIT_FILE    = "",
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Address decode; the byte offset bits never take part in any decision.
  // ---------------------------------------------------------------------------
  logic          sel_ram;
  logic          sel_tx;
  logic          sel_stat;
  logic          sel_cyc;
  logic [AW-1:0] ram_index;
  logic          unused_addr_bits;

  assign sel_ram          = (address[31:AW+2] == '0);
  assign sel_tx           = (address[31:2] == 30'h2000_0000);
  assign sel_stat         = (address[31:2] == 30'h2000_0001);
  assign sel_cyc          = (address[31:2] == 30'h2000_0002);
  assign ram_index        = address[AW+1:2];
  assign unused_addr_bits = ^address[1:0];

  // ---------------------------------------------------------------------------
  // RAM: full-word writes, asynchronous reads, contents survive reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  // Store a word on a write to RAM space; reset takes priority so writes are ignored then.
  always_ff @(posedge clk) begin
    if (!reset && we && sel_ram) begin
      ram[ram_index] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // UART TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          push;
  logic          pop;
  logic          overflow;
  logic          ovf_set;
  logic          ovf_clear;

  assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands then.
  assign push       = we && sel_tx && (!fifo_full || pop);
  assign ovf_set    = we && sel_tx && fifo_full && !pop;
  assign ovf_clear  = we && sel_stat && data_in[3];

  // Byte storage; pointer bookkeeping decides whether a stored byte is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_in[7:0];
    end
  end

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow flag; a fresh overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running cycle counter; a write load wins over the increment.
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_cnt;

  // Count every edge, or load the written value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (we && sel_cyc) begin
      cycle_cnt <= data_in;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmit FSM (8N1). uart_tx is registered from the next-state value so
  // the start bit appears the cycle after the pop edge.
  // ---------------------------------------------------------------------------
  tx_state_t     state;
  tx_state_t     state_n;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          bit_end;
  logic          busy;

  assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE);

  // State register; reset aborts any frame and drives the line idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      uart_tx   <= tx_n;
    end
  end

  // Next-state logic: bit timing, shifting, and back-to-back pops at the end of STOP.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    tx_n      = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        tx_n      = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_head;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
          tx_n      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = {1'b0, shift_reg[7:1]};
            tx_n      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
        tx_n      = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] stat_word;

  assign stat_word = {23'd0, 5'(fifo_count), overflow, busy, fifo_empty, fifo_full};

  // Combinational read of whichever target the address selects; unmapped reads give 0.
  always_comb begin
    data_out = '0;
    if (sel_ram) begin
      data_out = ram[ram_index];
    end else if (sel_stat) begin
      data_out = stat_word;
    end else if (sel_cyc) begin
      data_out = cycle_cnt;
    end
  end

endmodule

// File: tb/tb_memory_bus.sv
// tb_memory_bus: directed test of memory_bus with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_memory_bus;

  localparam logic [31:0] A_TX   = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
  logic        uart_tx;

  int check_count = 0;
  int error_count = 0;

  bit   capture_en = 1'b0;
  logic tx_log[$];

  memory_bus #(
    .RAM_WORDS   (1024),
    .INIT_FILE   (""),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data_in (data_in),
    .we      (we),
    .data_out(data_out),
    .uart_tx (uart_tx)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record the serial line once per cycle, mid-cycle, while capture is enabled.
  always @(negedge clk) begin
    if (capture_en) tx_log.push_back(uart_tx);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one bus cycle and let it be taken at the next rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wen);
    address = addr;
    data_in = data;
    we      = wen;
    step(1);
    we      = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    checkOutput(tag, data_out, exp);
  endtask

  initial begin
    logic [7:0] byte_a5;
    logic       exp_bit;
    logic [9:0] got_frame;
    logic [9:0] exp_frame;
    logic [7:0] bval;
    int         lows;

    reset   = 1'b1;
    we      = 1'b0;
    address = '0;
    data_in = '0;
    step(3);
    reset = 1'b0;

    // Reset state
    readCheck("rst_stat", A_STAT, 32'h0000_0002);
    checkOutput("rst_tx", {31'd0, uart_tx}, 32'd1);
    readCheck("rst_unmapped", 32'h8000_000C, 32'h0);
    readCheck("rst_tx_reg_read", A_TX, 32'h0);
    readCheck("rst_cycle", A_CYC, 32'h0);
    step(1);
    checkOutput("cycle_incr", data_out, 32'h1);

    // RAM and unmapped space
    applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    readCheck("ram_word", 32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram_byte_off", 32'h0000_0013, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0FFC, 32'h0BAD_F00D, 1'b1);
    readCheck("ram_last_word", 32'h0000_0FFC, 32'h0BAD_F00D);
    readCheck("ram_first_word", 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(32'h4000_0000, 32'h1234_5678, 1'b1);
    readCheck("unmapped_write", 32'h4000_0000, 32'h0);
    readCheck("beyond_ram", 32'h0000_1000, 32'h0);

    // Single frame of 0xA5
    byte_a5 = 8'hA5;
    applyStimulus(A_TX, 32'h0000_01A5, 1'b1);
    readCheck("stat_one_queued", A_STAT, 32'h0000_0010);
    checkOutput("tx_before_pop", {31'd0, uart_tx}, 32'd1);
    step(1);
    for (int i = 0; i < 40; i++) begin
      if (i / 4 == 0)      exp_bit = 1'b0;
      else if (i / 4 == 9) exp_bit = 1'b1;
      else                 exp_bit = byte_a5[i / 4 - 1];
      checkOutput($sformatf("frame_bit_c%0d", i), {31'd0, uart_tx}, {31'd0, exp_bit});
      checkOutput($sformatf("busy_c%0d", i), {31'd0, data_out[2]}, 32'd1);
      step(1);
    end
    checkOutput("tx_after_frame", {31'd0, uart_tx}, 32'd1);
    checkOutput("stat_after_frame", data_out, 32'h0000_0002);

    // Ten back-to-back writes: nine accepted, overflow set, frames abut
    for (int i = 0; i < 10; i++) begin
      applyStimulus(A_TX, 32'h30 + i, 1'b1);
      if (i == 1) capture_en = 1'b1;
    end
    readCheck("stat_overflow", A_STAT, 32'h0000_008D);
    applyStimulus(A_STAT, 32'h0000_0008, 1'b1);
    readCheck("stat_ovf_cleared", A_STAT, 32'h0000_0085);
    step(370);
    capture_en = 1'b0;
    checkOutput("log_len_ok", {31'd0, tx_log.size() >= 368}, 32'd1);
    if (tx_log.size() >= 368) begin
      for (int f = 0; f < 9; f++) begin
        bval      = 8'h30 + 8'(f);
        exp_frame = {1'b1, bval, 1'b0};
        for (int k = 0; k < 10; k++) got_frame[k] = tx_log[f * 40 + k * 4 + 2];
        checkOutput($sformatf("frame%0d", f), {22'd0, got_frame}, {22'd0, exp_frame});
      end
      lows = 0;
      for (int s = 360; s < 368; s++) if (tx_log[s] !== 1'b1) lows++;
      checkOutput("idle_after_nine", lows, 0);
    end
    readCheck("stat_drained", A_STAT, 32'h0000_0002);

    // CYCLE load and wrap
    applyStimulus(A_CYC, 32'hFFFF_FFFE, 1'b1);
    readCheck("cycle_load", A_CYC, 32'hFFFF_FFFE);
    step(1);
    checkOutput("cycle_max", data_out, 32'hFFFF_FFFF);
    step(1);
    checkOutput("cycle_wrap", data_out, 32'h0000_0000);

    // Reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) applyStimulus(A_TX, 32'h0, 1'b1);
    step(6);
    readCheck("stat_mid_frame", A_STAT, 32'h0000_0034);
    checkOutput("tx_data_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    we    = 1'b1;
    address = A_TX;
    data_in = 32'h55;
    step(1);
    reset = 1'b0;
    we    = 1'b0;
    checkOutput("tx_after_reset", {31'd0, uart_tx}, 32'd1);
    readCheck("stat_after_reset", A_STAT, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (uart_tx !== 1'b1) lows++;
    end
    checkOutput("no_frames_after_reset", lows, 0);
    readCheck("stat_still_idle", A_STAT, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
